// File: rtl/vedic_pkg.sv
// Shared widths and FSM state encoding for the sequential 16-by-8 divider.
package vedic_pkg;

    localparam int DIVIDEND_W = 16;
    localparam int DIVISOR_W  = 8;
    localparam int COUNT_W    = 5;

    localparam logic [COUNT_W-1:0] LAST_BIT = COUNT_W'(DIVIDEND_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: compare the 9-bit partial remainder against the
// divisor and subtract when it fits.
module div_step
    import vedic_pkg::*;
(
    input  logic [DIVISOR_W:0]   partial_i,
    input  logic [DIVISOR_W-1:0] divisor_i,
    output logic [DIVISOR_W-1:0] rem_o,
    output logic                 q_bit_o
);

    logic [DIVISOR_W-1:0] diff_lo;

    // The true difference is always below the divisor, so the low byte suffices.
    assign diff_lo = partial_i[DIVISOR_W-1:0] - divisor_i;
    assign q_bit_o = (partial_i >= {1'b0, divisor_i});
    assign rem_o   = q_bit_o ? diff_lo : partial_i[DIVISOR_W-1:0];

endmodule

// File: rtl/seq_divider_16by8.sv
// Sequential unsigned 16/8 restoring divider, one quotient bit per cycle.
// Define DIV_ZERO_DETECT_EN to short-cut zero divisors straight to DONE with err=1.
module seq_divider_16by8
    import vedic_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    state_e                state_q, state_d;
    logic [COUNT_W-1:0]    cnt_q, cnt_d;
    logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
    logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
    logic [DIVISOR_W-1:0]  rem_q, rem_d;
    logic [DIVIDEND_W-1:0] acc_q, acc_d;
    logic [DIVIDEND_W-1:0] quo_q, quo_d;
    logic [DIVISOR_W-1:0]  remo_q, remo_d;

    logic [DIVISOR_W-1:0]  step_rem;
    logic                  step_q;

    div_step u_step (
        .partial_i (({rem_q, dvd_q[DIVIDEND_W-1]})),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_q)
    );

`ifdef DIV_ZERO_DETECT_EN
    logic err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        acc_d   = acc_q;
        quo_d   = quo_q;
        remo_d  = remo_q;
`ifdef DIV_ZERO_DETECT_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    cnt_d   = '0;
                    rem_d   = '0;
                    acc_d   = '0;
                    state_d = BUSY;
`ifdef DIV_ZERO_DETECT_EN
                    err_d = (divisor == '0);
                    if (divisor == '0) begin
                        state_d = DONE;
                        quo_d   = '1;
                        remo_d  = dividend[DIVISOR_W-1:0];
                    end
`endif
                end
            end
            BUSY: begin
                dvd_d = dvd_q << 1;
                rem_d = step_rem;
                acc_d = {acc_q[DIVIDEND_W-2:0], step_q};
                cnt_d = cnt_q + COUNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                    quo_d   = {acc_q[DIVIDEND_W-2:0], step_q};
                    remo_d  = step_rem;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            acc_q   <= '0;
            quo_q   <= '0;
            remo_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            acc_q   <= acc_d;
            quo_q   <= quo_d;
            remo_q  <= remo_d;
        end
    end

`ifdef DIV_ZERO_DETECT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign quotient  = quo_q;
    assign remainder = remo_q;
    assign busy      = (state_q == BUSY);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_seq_divider_16by8.sv
// Randomized and directed bench for seq_divider_16by8 against an arithmetic model.
module tb_seq_divider_16by8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        busy;
    logic        done;
    logic        err;

    int checks   = 0;
    int failures = 0;

    // {err, quotient, remainder}
    logic [24:0] exp_q[$];

    seq_divider_16by8 dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic logic [24:0] model(input logic [15:0] dd, input logic [7:0] ds);
        int unsigned q, r;
        logic        e;
        if (ds == 0) begin
            q = 16'hFFFF;
            r = dd & 16'h00FF;
`ifdef DIV_ZERO_DETECT_EN
            e = 1'b1;
`else
            e = 1'b0;
`endif
        end else begin
            q = dd / ds;
            r = dd % ds;
            e = 1'b0;
        end
        return {e, q[15:0], r[7:0]};
    endfunction

    function automatic int exp_latency(input logic [7:0] ds);
`ifdef DIV_ZERO_DETECT_EN
        if (ds == 0) return 1;
`endif
        return 17;
    endfunction

    // Cycles counted as negedge samples after the accepting edge.
    task automatic run_div(input logic [15:0] dd, input logic [7:0] ds, input bit inject);
        int          cyc;
        int          lat;
        int          extra;
        bit          got;
        logic [24:0] e;
        lat = exp_latency(ds);
        exp_q.push_back(model(dd, ds));
        @(negedge clk);
        dividend = dd;
        divisor  = ds;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (inject && (cyc == 5 || cyc == 16)) begin
                start    = 1'b1;
                dividend = 16'($urandom);
                divisor  = 8'($urandom_range(1, 255));
            end else begin
                start = 1'b0;
            end
            if (cyc == 1 && lat == 17) check("busy_running", {31'd0, busy}, 32'd1);
            if (done) got = 1'b1;
        end
        start = 1'b0;
        check("done_seen", {31'd0, got}, 32'd1);
        check("latency", cyc, lat);
        e = exp_q.pop_front();
        if (got) begin
            check("quotient", {16'd0, quotient}, {16'd0, e[23:8]});
            check("remainder", {24'd0, remainder}, {24'd0, e[7:0]});
            check("err", {31'd0, err}, {31'd0, e[24]});
            check("busy_in_done", {31'd0, busy}, 32'd0);
            @(negedge clk);
            check("done_pulse_width", {31'd0, done}, 32'd0);
            check("hold_quotient", {16'd0, quotient}, {16'd0, e[23:8]});
        end
        if (inject) begin
            extra = 0;
            for (int i = 0; i < 25; i++) begin
                @(negedge clk);
                if (done || busy) extra++;
            end
            check("no_restart", extra, 0);
        end
    endtask

    task automatic reset_abort_test();
        int stray;
        @(negedge clk);
        dividend = 16'h9999;
        divisor  = 8'd13;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 8; i++) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_quotient", {16'd0, quotient}, 32'd0);
        check("rst_remainder", {24'd0, remainder}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        stray = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done || busy) stray++;
        end
        check("no_done_after_abort", stray, 0);
        run_div(16'd100, 8'd7, 1'b0);
    endtask

    initial begin
        logic [15:0] dd;
        logic [7:0]  ds;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #12;
        check("reset_quotient", {16'd0, quotient}, 32'd0);
        check("reset_remainder", {24'd0, remainder}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_div(16'd65025, 8'd255, 1'b0);
        run_div(16'd15, 8'd3, 1'b0);
        run_div(16'd8, 8'd2, 1'b0);
        run_div(16'd48, 8'd8, 1'b0);
        run_div(16'd65535, 8'd7, 1'b0);
        run_div(16'h1234, 8'd0, 1'b0);
        run_div(16'd200, 8'd250, 1'b0);
        run_div(16'd40000, 8'd1, 1'b0);
        run_div(16'd0, 8'd9, 1'b0);
        run_div(16'd51234, 8'd77, 1'b1);
        reset_abort_test();

        for (int n = 0; n < 30; n++) begin
            dd = 16'($urandom);
            if ($urandom_range(0, 7) == 0)      ds = 8'd0;
            else if ($urandom_range(0, 3) == 0) ds = 8'($urandom_range(1, 4));
            else                                ds = 8'($urandom_range(1, 255));
            run_div(dd, ds, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
